// File: rtl/nco_tone_sequencer_if.sv
// Step-table write bus for nco_tone_sequencer: one synchronous write per wr_en_i cycle.
interface nco_tone_sequencer_if #(
  parameter int ACC_WIDTH  = 16,
  parameter int DUR_WIDTH  = 16,
  parameter int DEPTH_LOG2 = 4
);
  logic                  wr_en_i;
  logic [DEPTH_LOG2-1:0] wr_addr_i;
  logic [ACC_WIDTH-1:0]  wr_inc_i;
  logic [DUR_WIDTH-1:0]  wr_dur_i;
  logic                  wr_last_i;

  modport master (output wr_en_i, wr_addr_i, wr_inc_i, wr_dur_i, wr_last_i);
  modport slave  (input  wr_en_i, wr_addr_i, wr_inc_i, wr_dur_i, wr_last_i);
endinterface

// File: rtl/nco_tone_sequencer.sv
// Tone-step sequencer feeding the NCO phase increment; steps advance on sample strobes.
// Define NCO_GLIDE_EN to build the portamento (glide) path on acc_o.
module nco_tone_sequencer #(
  parameter int ACC_WIDTH   = 16,
  parameter int DUR_WIDTH   = 16,
  parameter int DEPTH_LOG2  = 4,
  parameter int GLIDE_SHIFT = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_n,
  nco_tone_sequencer_if.slave   wr,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic                  loop_i,
  input  logic                  sample_stb_i,
  output logic [ACC_WIDTH-1:0]  acc_o,
  output logic                  gate_o,
  output logic                  busy_o,
  output logic [DEPTH_LOG2-1:0] step_o,
  output logic                  done_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  if (GLIDE_SHIFT < 1 || GLIDE_SHIFT >= ACC_WIDTH) begin : g_bad_glide_shift
    $error("GLIDE_SHIFT must lie in [1, ACC_WIDTH-1]");
  end

  typedef enum logic [1:0] {IDLE, FETCH, PLAY, DONE} state_t;

  state_t               state;
  logic [ACC_WIDTH-1:0] inc_mem  [DEPTH];
  logic [DUR_WIDTH-1:0] dur_mem  [DEPTH];
  logic                 last_mem [DEPTH];
  logic [ACC_WIDTH-1:0] inc_r;
  logic                 last_r;
  logic [DUR_WIDTH-1:0] cnt;
  logic [ACC_WIDTH-1:0] acc_next;

  // Table has no reset; a same-cycle FETCH of the written address sees old data.
  always_ff @(posedge clk_i) begin
    if (wr.wr_en_i) begin
      inc_mem[wr.wr_addr_i]  <= wr.wr_inc_i;
      dur_mem[wr.wr_addr_i]  <= wr.wr_dur_i;
      last_mem[wr.wr_addr_i] <= wr.wr_last_i;
    end
  end

`ifdef NCO_GLIDE_EN
  logic signed [ACC_WIDTH-1:0] sdiff;
  logic signed [ACC_WIDTH-1:0] sshift;

  // Arithmetic shift floors to zero near the target; force a unit step so acc_o lands on inc_r.
  always_comb begin
    sdiff  = signed'(inc_r - acc_o);
    sshift = sdiff >>> GLIDE_SHIFT;
    if (sshift == '0 && sdiff != '0)
      acc_next = acc_o + {{(ACC_WIDTH-1){sdiff[ACC_WIDTH-1]}}, 1'b1};
    else
      acc_next = acc_o + unsigned'(sshift);
  end
`else
  always_comb begin
    acc_next = inc_r;
  end
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state  <= IDLE;
      acc_o  <= '0;
      gate_o <= 1'b0;
      busy_o <= 1'b0;
      step_o <= '0;
      done_o <= 1'b0;
      cnt    <= '0;
      inc_r  <= '0;
      last_r <= 1'b0;
    end else if (stop_i) begin
      state  <= IDLE;
      acc_o  <= '0;
      gate_o <= 1'b0;
      busy_o <= 1'b0;
      step_o <= '0;
      done_o <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          acc_o  <= '0;
          gate_o <= 1'b0;
          done_o <= 1'b0;
          if (start_i) begin
            state  <= FETCH;
            step_o <= '0;
            busy_o <= 1'b1;
          end
        end
        FETCH: begin
          inc_r  <= inc_mem[step_o];
          last_r <= last_mem[step_o];
          cnt    <= (dur_mem[step_o] == '0) ? DUR_WIDTH'(1) : dur_mem[step_o];
`ifndef NCO_GLIDE_EN
          acc_o  <= inc_mem[step_o];
`endif
          gate_o <= 1'b1;
          state  <= PLAY;
        end
        PLAY: begin
`ifndef NCO_GLIDE_EN
          acc_o <= acc_next;
`endif
          if (sample_stb_i) begin
`ifdef NCO_GLIDE_EN
            acc_o <= acc_next;
`endif
            cnt <= cnt - DUR_WIDTH'(1);
            if (cnt == DUR_WIDTH'(1)) begin
              if (!last_r) begin
                step_o <= step_o + DEPTH_LOG2'(1);
                state  <= FETCH;
              end else if (loop_i) begin
                step_o <= '0;
                state  <= FETCH;
              end else begin
                state  <= DONE;
                done_o <= 1'b1;
                gate_o <= 1'b0;
                acc_o  <= '0;
              end
            end
          end
        end
        DONE: begin
          done_o <= 1'b0;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nco_tone_sequencer.sv
// Directed bench for nco_tone_sequencer; expected values are hand-computed constants.
module tb_nco_tone_sequencer;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int DL = 4;

  logic          clk_i = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0, stop_i = 1'b0, loop_i = 1'b0, sample_stb_i = 1'b0;
  logic [AW-1:0] acc_o;
  logic          gate_o, busy_o, done_o;
  logic [DL-1:0] step_o;

  int unsigned total = 0;
  int unsigned bad   = 0;

  nco_tone_sequencer_if #(.ACC_WIDTH(AW), .DUR_WIDTH(DW), .DEPTH_LOG2(DL)) wr_bus ();

  nco_tone_sequencer #(
    .ACC_WIDTH(AW), .DUR_WIDTH(DW), .DEPTH_LOG2(DL), .GLIDE_SHIFT(3)
  ) dut (
    .clk_i(clk_i), .rst_n(rst_n), .wr(wr_bus.slave),
    .start_i(start_i), .stop_i(stop_i), .loop_i(loop_i), .sample_stb_i(sample_stb_i),
    .acc_o(acc_o), .gate_o(gate_o), .busy_o(busy_o), .step_o(step_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic wr_step(input logic [DL-1:0] a, input logic [AW-1:0] inc,
                         input logic [DW-1:0] dur, input logic last);
    wr_bus.wr_addr_i = a;
    wr_bus.wr_inc_i  = inc;
    wr_bus.wr_dur_i  = dur;
    wr_bus.wr_last_i = last;
    wr_bus.wr_en_i   = 1'b1;
    tick(1);
    wr_bus.wr_en_i   = 1'b0;
  endtask

  task automatic strobe();
    sample_stb_i = 1'b1;
    tick(1);
    sample_stb_i = 1'b0;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick(1);
    start_i = 1'b0;
  endtask

  task automatic pulse_stop();
    stop_i = 1'b1;
    tick(1);
    stop_i = 1'b0;
  endtask

`ifndef NCO_GLIDE_EN
  logic [AW-1:0] exp_acc  [6] = '{16'h0800, 16'h0800, 16'h1000, 16'h1000, 16'h1000, 16'h2000};
  logic [DL-1:0] exp_step [6] = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2};
`endif

  initial begin
    wr_bus.wr_en_i = 1'b0; wr_bus.wr_addr_i = '0; wr_bus.wr_inc_i = '0;
    wr_bus.wr_dur_i = '0;  wr_bus.wr_last_i = 1'b0;
    tick(3);
    rst_n = 1'b1;
    check("rst_acc",  acc_o,  0);
    check("rst_gate", gate_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);

`ifndef NCO_GLIDE_EN
    // Three-step run, no loop
    wr_step(0, 16'h0800, 2, 0);
    wr_step(1, 16'h1000, 3, 0);
    wr_step(2, 16'h2000, 1, 1);
    pulse_start();
    check("fetch_busy", busy_o, 1);
    check("fetch_gate", gate_o, 0);
    tick(1);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("run_acc%0d", i),  acc_o,  exp_acc[i]);
      check($sformatf("run_step%0d", i), step_o, exp_step[i]);
      check($sformatf("run_gate%0d", i), gate_o, 1);
      strobe();
      if (i < 5) tick(9);
    end
    check("end_done", done_o, 1);
    check("end_gate", gate_o, 0);
    check("end_acc",  acc_o,  0);
    tick(1);
    check("end_done_clr", done_o, 0);
    check("end_idle",     busy_o, 0);

    // Loop, then stop mid-step-1
    loop_i = 1'b1;
    pulse_start();
    tick(1);
    for (int i = 0; i < 6; i++) begin
      strobe();
      tick(9);
    end
    check("loop_acc",  acc_o,  16'h0800);
    check("loop_step", step_o, 0);
    check("loop_busy", busy_o, 1);
    strobe(); tick(9);
    strobe(); tick(9);
    check("loop_s1", acc_o, 16'h1000);
    strobe(); tick(3);
    pulse_stop();
    check("stop_busy", busy_o, 0);
    check("stop_acc",  acc_o,  0);
    check("stop_gate", gate_o, 0);
    check("stop_step", step_o, 0);
    check("stop_done", done_o, 0);
    tick(2);
    check("stop_done2", done_o, 0);

    // Write hazard: rewrite entry 1 while it plays
    pulse_start();
    tick(1);
    strobe(); tick(9);
    strobe(); tick(9);
    check("hz_before", acc_o, 16'h1000);
    wr_step(1, 16'h3000, 3, 0);
    tick(2);
    check("hz_held", acc_o, 16'h1000);
    for (int i = 0; i < 6; i++) begin
      strobe();
      tick(9);
    end
    check("hz_step", step_o, 1);
    check("hz_new",  acc_o,  16'h3000);
    pulse_stop();

    // dur=0 plays for one strobe
    loop_i = 1'b0;
    wr_step(0, 16'h0400, 0, 1);
    pulse_start();
    tick(1);
    check("dur0_acc", acc_o, 16'h0400);
    strobe();
    check("dur0_done", done_o, 1);
    tick(2);
    check("dur0_idle", busy_o, 0);

    // No last bit anywhere: wraps 15 -> 0
    for (int i = 0; i < 16; i++) wr_step(DL'(i), AW'((i + 1) * 16'h0100), 1, 0);
    pulse_start();
    tick(1);
    for (int i = 0; i < 17; i++) begin
      check($sformatf("wrap_step%0d", i), step_o, (i % 16));
      check($sformatf("wrap_acc%0d", i),  acc_o,  ((i % 16) + 1) * 16'h0100);
      strobe();
      tick(2);
    end
    // start while busy: now on step 1, must not restart at 0
    check("busy_pre", step_o, 1);
    pulse_start();
    tick(2);
    check("busy_start_step", step_o, 1);
    check("busy_start_acc",  acc_o,  16'h0200);
    pulse_stop();

    // start and stop together in IDLE
    start_i = 1'b1; stop_i = 1'b1;
    tick(1);
    start_i = 1'b0; stop_i = 1'b0;
    tick(2);
    check("ss_busy", busy_o, 0);
    check("ss_gate", gate_o, 0);

    // Reset held 3 cycles mid-PLAY
    wr_step(0, 16'h0800, 5, 1);
    pulse_start();
    tick(1);
    check("pre_rst_gate", gate_o, 1);
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    check("mrst_acc",  acc_o,  0);
    check("mrst_gate", gate_o, 0);
    check("mrst_busy", busy_o, 0);
    check("mrst_done", done_o, 0);
    check("mrst_step", step_o, 0);
`else
    // Glide from 0 toward 0x0100 with shift 3
    begin
      logic [AW-1:0] gl_exp [38] = '{
        16'h020, 16'h03C, 16'h054, 16'h069, 16'h07B, 16'h08B, 16'h099, 16'h0A5,
        16'h0B0, 16'h0BA, 16'h0C2, 16'h0C9, 16'h0CF, 16'h0D5, 16'h0DA, 16'h0DE,
        16'h0E2, 16'h0E5, 16'h0E8, 16'h0EB, 16'h0ED, 16'h0EF, 16'h0F1, 16'h0F2,
        16'h0F3, 16'h0F4, 16'h0F5, 16'h0F6, 16'h0F7, 16'h0F8, 16'h0F9, 16'h0FA,
        16'h0FB, 16'h0FC, 16'h0FD, 16'h0FE, 16'h0FF, 16'h100};
      wr_step(0, 16'h0100, 40, 1);
      pulse_start();
      tick(1);
      check("gl_start", acc_o, 0);
      check("gl_gate",  gate_o, 1);
      for (int i = 0; i < 38; i++) begin
        strobe();
        check($sformatf("gl_acc%0d", i), acc_o, gl_exp[i]);
        tick(2);
      end
      strobe();
      check("gl_hold", acc_o, 16'h0100);
      tick(2);
      strobe();
      check("gl_done", done_o, 1);
      tick(2);
      check("gl_idle", busy_o, 0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/nco_tone_sequencer.md
Name: nco_tone_sequencer

Overview:
Programmable tone-step sequencer that drives the phase-increment input of the NCO in the audio path. It holds a small table of (increment, duration, last) steps and plays them in order. Steps advance on the codec sample strobe, so the DAC receives timed tone sequences (beeps, melodies, test tones) without CPU involvement. It has start/stop control, looping, and a done pulse for the host.

Parameters:
ACC_WIDTH, 16, width of phase increment; matches the NCO accumulator width.
DUR_WIDTH, 16, width of the per-step duration counter, in sample strobes.
DEPTH_LOG2, 4, log2 of the step-table depth (16 entries).
GLIDE_SHIFT, 3, glide slew shift; used only when NCO_GLIDE_EN is defined.

Ports:
clk_i  in  1  system clock; all logic rises on posedge.
rst_n  in  1  synchronous active-low reset, sampled on posedge clk_i.
wr_en_i  in  1  table write strobe.
wr_addr_i  in  DEPTH_LOG2  table write address.
wr_inc_i  in  ACC_WIDTH  step phase increment.
wr_dur_i  in  DUR_WIDTH  step duration in sample strobes (0 treated as 1).
wr_last_i  in  1  marks the step as the end of the sequence.
start_i  in  1  start pulse; honoured only in IDLE.
stop_i  in  1  abort pulse.
loop_i  in  1  level; when 1, the sequence restarts at step 0 after the last step.
sample_stb_i  in  1  one-cycle pulse per audio sample (e.g. LRCK edge).
acc_o  out  ACC_WIDTH  phase increment to the NCO acc_i input.
gate_o  out  1  tone active; the audio mux uses it to select NCO output or silence.
busy_o  out  1  high in any state other than IDLE.
step_o  out  DEPTH_LOG2  index of the current step.
done_o  out  1  one-cycle pulse at natural sequence end.

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE; acc_o, gate_o, busy_o, step_o, done_o and the duration counter all 0. Table contents are not reset.
- Table: DEPTH_LOG2-addressed synchronous-write array of {inc, dur, last}. Writes are accepted in every state.
  - A write to the entry currently playing takes effect only at its next FETCH.
  - A same-cycle write and FETCH of one address returns the old data.
- States: IDLE, FETCH, PLAY, DONE.
- IDLE: acc_o=0, gate_o=0. start_i=1 -> FETCH with step=0.
- FETCH (1 cycle):
  - Latch table[step] into inc_r, dur_r, last_r.
  - Set cnt = max(dur, 1) and acc_o = inc; go to PLAY.
  - acc_o keeps its previous value during FETCH, so there is no zero glitch between steps.
- PLAY: gate_o=1, acc_o=inc_r.
  - Each sample_stb_i decrements cnt.
  - When sample_stb_i arrives with cnt==1:
    - last_r=0: step <= step+1 (wraps at 2^DEPTH_LOG2-1 to 0), go to FETCH.
    - last_r=1 and loop_i=1: step <= 0, go to FETCH.
    - last_r=1 and loop_i=0: go to DONE.
  - sample_stb_i is ignored in IDLE, FETCH and DONE.
- DONE (1 cycle): done_o=1, gate_o=0, acc_o=0; then IDLE.
- Latency: start_i in cycle N -> FETCH in N+1 -> acc_o and gate_o valid in N+2.
- Step duration: exactly max(dur,1) sample strobes counted in PLAY, plus 1 FETCH cycle of clk_i.
- stop_i has priority over everything else. In FETCH, PLAY or DONE it forces IDLE next cycle with acc_o=0, gate_o=0, step_o=0, and no done_o pulse.
- start_i while busy_o=1 is ignored. Simultaneous start_i and stop_i in IDLE: stay in IDLE.
- Table with no last bit set: steps wrap through all entries forever until stop_i.
- gate_o=0 and acc_o=0 in IDLE and DONE; the NCO keeps running but the audio mux outputs silence.

Optional Feature:
Macro NCO_GLIDE_EN.
- Defined: the glide (portamento) path is built.
  - In PLAY, on each sample_stb_i, acc_o <= acc_o + sdiff>>>GLIDE_SHIFT, where sdiff = signed(inc_r - acc_o).
  - If the shifted value is 0 and sdiff != 0, acc_o moves by ±1, so it always reaches inc_r.
  - FETCH does not load acc_o; the first step glides up from 0.
  - Durations are unchanged.
- Not defined: the glide logic is absent and acc_o loads inc directly in FETCH.

Test Plan:
1. Reset: hold rst_n=0 for 3 cycles mid-PLAY -> next cycle acc_o=0, gate_o=0, busy_o=0, done_o=0, step_o=0.
2. Three-step run: load steps 0..2 = {0x0800,2,0},{0x1000,3,0},{0x2000,1,1}; loop_i=0; pulse start_i; strobe every 10 cycles.
   - acc_o reads 0x0800 for 2 strobes, then 0x1000 for 3, then 0x2000 for 1.
   - done_o pulses once, then IDLE.
3. Loop: same table with loop_i=1 -> after step 2 it returns to step 0 (0x0800). stop_i mid-step-1 -> IDLE next cycle, no done_o.
4. Edges:
   - dur=0 entry plays for 1 strobe.
   - Table with no last bit wraps 15 -> 0.
   - start_i while busy is ignored.
   - start_i and stop_i together in IDLE stays in IDLE.
5. Write hazard: rewrite the playing entry 1 to inc=0x3000 during PLAY -> acc_o unchanged until the next loop pass, which shows 0x3000.
6. NCO_GLIDE_EN defined, GLIDE_SHIFT=3, step 0x0000 -> 0x0100:
   - Strobe 1: acc_o=0x0020. Strobe 2: acc_o=0x003C.
   - acc_o converges exactly to 0x0100 with no overshoot.
